// File: rtl/game_pkg.sv
// Shared definitions for the block-killer game: state encoding, score/level limits
// and the score-to-level mapping.
package game_pkg;

   typedef enum logic [1:0] {
      STATE_START = 2'b00,
      STATE_PLAY  = 2'b01,
      STATE_OVER  = 2'b10
   } game_state_t;

   localparam int unsigned MAX_LEVEL = 7;
   localparam int unsigned SCORE_MAX = 255;

   // Level is the score scaled down by 2^shift, clamped to the top difficulty.
   function automatic logic [2:0] score_to_level(input logic [7:0] score_val,
                                                 input int unsigned shift);
      logic [7:0] raw;
      raw = score_val >> shift;
      return (raw > 8'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : raw[2:0];
   endfunction

endpackage

// File: rtl/game_flow_ctrl_tick_gen.sv
// Programmable-period pulse generator. Fires when the count reaches period-1 or beyond,
// so a period shortened below the current count fires on the next cycle instead of wrapping.
module tick_gen (
   input  logic        CLK_50M,
   input  logic        RST_N,
   input  logic        enable,
   input  logic        clear,
   input  logic [31:0] period,
   output logic        tick
);

   logic [31:0] cnt;

   always_ff @(posedge CLK_50M) begin
      if (!RST_N) begin
         cnt  <= 32'd0;
         tick <= 1'b0;
      end else if (clear) begin
         cnt  <= 32'd0;
         tick <= 1'b0;
      end else if (enable) begin
         if (cnt >= period - 32'd1) begin
            cnt  <= 32'd0;
            tick <= 1'b1;
         end else begin
            cnt  <= cnt + 32'd1;
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: START/PLAY/OVER flow, score and level tracking,
// post-game key lockout and the level-dependent block drop tick.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int unsigned TICK_BASE   = 25_000_000,
   parameter int unsigned TICK_STEP   = 2_500_000,
   parameter int unsigned LEVEL_SHIFT = 3,
   parameter int unsigned OVER_HOLD   = 100_000_000
) (
   input  logic       CLK_50M,
   input  logic       RST_N,
   input  logic       left_key_press,
   input  logic       right_key_press,
   input  logic       down_key_press,
   input  logic       hit_pulse,
   input  logic       game_over,
   output logic [1:0] game_state,
   output logic       drop_tick,
   output logic       field_clear,
   output logic [7:0] score,
   output logic [2:0] level
);

   game_state_t state, state_nxt;
   logic        any_key;
   logic        start_round;
   logic        play_run;
   logic        hold_done;
   logic [31:0] hold_cnt;
   logic [31:0] period;

   assign any_key    = left_key_press | right_key_press | down_key_press;
   assign hold_done  = (hold_cnt == 32'(OVER_HOLD));
   assign period     = 32'(TICK_BASE) - 32'(level) * 32'(TICK_STEP);
   assign game_state = state;

   always_comb begin
      state_nxt   = state;
      start_round = 1'b0;
      play_run    = 1'b0;
      case (state)
         STATE_START: begin
            if (any_key) begin
               state_nxt   = STATE_PLAY;
               start_round = 1'b1;
            end
         end
         STATE_PLAY: begin
            // game_over wins over hits, ticks and keys in the same cycle
            if (game_over) state_nxt = STATE_OVER;
            else           play_run  = 1'b1;
         end
         STATE_OVER: begin
            if (any_key && hold_done) state_nxt = STATE_START;
         end
         default: state_nxt = STATE_START;
      endcase
   end

   always_ff @(posedge CLK_50M) begin
      if (!RST_N) begin
         state       <= STATE_START;
         score       <= 8'd0;
         level       <= 3'd0;
         field_clear <= 1'b0;
         hold_cnt    <= 32'd0;
      end else begin
         state       <= state_nxt;
         field_clear <= start_round;
         if (start_round) begin
            score <= 8'd0;
            level <= 3'd0;
         end else begin
            level <= score_to_level(score, LEVEL_SHIFT);
            if (play_run && hit_pulse && (score != 8'(SCORE_MAX)))
               score <= score + 8'd1;
         end
         // Lockout counter restarts on every entry into OVER and parks at OVER_HOLD
         if (state != STATE_OVER) hold_cnt <= 32'd0;
         else if (!hold_done)     hold_cnt <= hold_cnt + 32'd1;
      end
   end

   tick_gen u_tick_gen (
      .CLK_50M (CLK_50M),
      .RST_N   (RST_N),
      .enable  (play_run),
      .clear   (start_round),
      .period  (period),
      .tick    (drop_tick)
   );

endmodule
